// File: rtl/counter_pkg.sv
// Shared definitions for the count-enable source: debounce FSM state encoding,
// default timing constants and a counter-width helper.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  localparam int unsigned DEF_PRESCALE        = 100000000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchroniser plus four-state debounce FSM for a raw pushbutton.
// Produces the registered debounced level and a one-cycle pulse on each
// accepted press; releases never pulse.
module btn_debouncer
  import counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_lvl,
  output logic press_pulse
);

  localparam int unsigned     DW    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]   DLAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          bsync1;
  logic          bsync;
  deb_state_e    state;
  logic [DW-1:0] dcnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bsync1 <= 1'b0;
      bsync  <= 1'b0;
    end else begin
      bsync1 <= btn;
      bsync  <= bsync1;
    end
  end

  // Press acceptance is decoded from current state so the top can register E on
  // the same edge the FSM enters PRESSED; this keeps step latency at D+1 edges.
  assign press_pulse = (state == PRESS_WAIT) && bsync && (dcnt == DLAST);

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive stable synced samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dcnt    <= '0;
      btn_lvl <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bsync) begin
            state <= PRESS_WAIT;
            dcnt  <= DW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!bsync) begin
            state <= IDLE;
            dcnt  <= '0;
          end else if (dcnt == DLAST) begin
            state   <= PRESSED;
            dcnt    <= '0;
            btn_lvl <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!bsync) begin
            state <= RELEASE_WAIT;
            dcnt  <= DW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (bsync) begin
            state <= PRESSED;
            dcnt  <= '0;
          end else if (dcnt == DLAST) begin
            state   <= IDLE;
            dcnt    <= '0;
            btn_lvl <= 1'b0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          dcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/count_enable_gen.sv
// Count-enable source for the 4-bit up counter: debounced single-step presses
// in step mode, a periodic prescaler tick in run mode. E is registered and one
// cycle wide per event.
module count_enable_gen
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE        = DEF_PRESCALE,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic CLK,
  input  logic CLR,
  input  logic BTN,
  input  logic RUN,
  output logic E,
  output logic BTN_LVL,
  output logic MODE
);

  localparam int unsigned   PW    = cnt_width(PRESCALE);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic          run_sync1;
  logic [PW-1:0] pcnt;
  logic          press_pulse;
  logic          wrap;
  logic          e_d;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk        (CLK),
    .rst_n      (CLR),
    .btn        (BTN),
    .btn_lvl    (BTN_LVL),
    .press_pulse(press_pulse)
  );

  // Synchronise the mode switch; MODE is the second flop.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      run_sync1 <= 1'b0;
      MODE      <= 1'b0;
    end else begin
      run_sync1 <= RUN;
      MODE      <= run_sync1;
    end
  end

  // Wrap only counts while in run mode, so leaving run mode cannot add a pulse
  // beyond one coinciding with the final run-mode edge.
  always_comb begin
    wrap = MODE && (pcnt == PLAST);
    e_d  = (press_pulse && !MODE) || wrap;
  end

  // Prescaler: held at zero in step mode, so entering run mode restarts a full period.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      pcnt <= '0;
    end else if (!MODE || wrap) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Registered enable to the downstream counter.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      E <= 1'b0;
    end else begin
      E <= e_d;
    end
  end

endmodule

// File: tb/tb_count_enable_gen.sv
// Self-checking bench for count_enable_gen with DEBOUNCE_CYCLES=4, PRESCALE=5.
// Expected E pulse times are pushed when stimulus is driven and compared
// against the pulse times observed on the output.
module tb_count_enable_gen;
  import counter_pkg::*;

  localparam int unsigned D = 4;
  localparam int unsigned P = 5;

  logic CLK;
  logic CLR;
  logic BTN;
  logic RUN;
  logic E;
  logic BTN_LVL;
  logic MODE;

  count_enable_gen #(
    .PRESCALE       (P),
    .DEBOUNCE_CYCLES(D)
  ) u_dut (
    .CLK    (CLK),
    .CLR    (CLR),
    .BTN    (BTN),
    .RUN    (RUN),
    .E      (E),
    .BTN_LVL(BTN_LVL),
    .MODE   (MODE)
  );

  typedef struct {
    int   hi;
    int   lo;
    logic exp_pulse;
    logic exp_lvl;
  } vec_t;

  vec_t       vecs[6];
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  int         k;
  int         m;
  int         exp_q[$];
  int         seen_q[$];
  logic       e_prev = 1'b0;
  logic [3:0] cnt;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Downstream 4-bit counter driven by E.
  always @(posedge CLK or negedge CLR) begin
    if (!CLR) cnt <= 4'd0;
    else if (E) cnt <= cnt + 4'd1;
  end

  // Record every E pulse (edge index after which it appeared); E may never repeat.
  always @(negedge CLK) begin
    if (E === 1'b1) begin
      seen_q.push_back(cyc);
      tests++;
      if (e_prev) begin
        fails++;
        $display("FAIL e_consecutive: E high at cycle %0d and previous, required single-cycle", cyc);
      end
    end
    e_prev = (E === 1'b1);
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name);
    int a;
    int b;
    tests++;
    if (seen_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s pulse count: got %0d required %0d", name, seen_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && seen_q.size() > 0) begin
      a = exp_q.pop_front();
      b = seen_q.pop_front();
      tests++;
      if (a != b) begin
        fails++;
        $display("FAIL %s pulse time: got cycle %0d required cycle %0d", name, b, a);
      end
    end
    exp_q.delete();
    seen_q.delete();
  endtask

  initial begin
    vecs[0] = '{hi: 1,  lo: 10, exp_pulse: 1'b0, exp_lvl: 1'b0};
    vecs[1] = '{hi: 2,  lo: 10, exp_pulse: 1'b0, exp_lvl: 1'b0};
    vecs[2] = '{hi: 3,  lo: 10, exp_pulse: 1'b0, exp_lvl: 1'b0};
    vecs[3] = '{hi: 4,  lo: 10, exp_pulse: 1'b1, exp_lvl: 1'b1};
    vecs[4] = '{hi: 20, lo: 10, exp_pulse: 1'b1, exp_lvl: 1'b1};
    vecs[5] = '{hi: 5,  lo: 10, exp_pulse: 1'b1, exp_lvl: 1'b1};

    // Reset held with both raw inputs high.
    CLR = 1'b1;
    BTN = 1'b1;
    RUN = 1'b1;
    #1 CLR = 1'b0;
    cyc_wait(3);
    check("reset_e", E, 0);
    check("reset_btn_lvl", BTN_LVL, 0);
    check("reset_mode", MODE, 0);
    BTN = 1'b0;
    RUN = 1'b0;
    cyc_wait(1);
    CLR = 1'b1;
    cyc_wait(20);
    sb_check("reset_idle");

    // Step-mode presses of varying width; a press is accepted after D high samples.
    for (int i = 0; i < 6; i++) begin
      BTN = 1'b1;
      k = cyc + 1;
      if (vecs[i].exp_pulse) exp_q.push_back(k + D + 1);
      cyc_wait(vecs[i].hi);
      BTN = 1'b0;
      cyc_wait(2);
      check($sformatf("vec%0d_lvl_held", i), BTN_LVL, vecs[i].exp_lvl);
      cyc_wait(vecs[i].lo - 2);
      check($sformatf("vec%0d_lvl_released", i), BTN_LVL, 0);
    end
    sb_check("step_table");

    // Bounce 1,0,1,0 then held high: single pulse D+1 edges after final rising sample.
    k = cyc + 1;
    BTN = 1'b1; cyc_wait(1);
    BTN = 1'b0; cyc_wait(1);
    BTN = 1'b1; cyc_wait(1);
    BTN = 1'b0; cyc_wait(1);
    BTN = 1'b1;
    exp_q.push_back(k + 4 + D + 1);
    cyc_wait(12);
    BTN = 1'b0;
    cyc_wait(10);
    check("bounce_lvl", BTN_LVL, 0);
    sb_check("bounce");

    // Run mode: MODE two edges after RUN, pulse every P cycles, presses discarded.
    RUN = 1'b1;
    k = cyc + 1;
    cyc_wait(1);
    check("mode_lat1", MODE, 0);
    cyc_wait(1);
    check("mode_lat2", MODE, 1);
    m = k + 1;
    for (int i = 1; i <= 10; i++) exp_q.push_back(m + i * P);
    cyc_wait(10);
    BTN = 1'b1;
    cyc_wait(8);
    check("run_btn_lvl", BTN_LVL, 1);
    BTN = 1'b0;
    cyc_wait(10);
    cyc_wait(23);
    RUN = 1'b0;
    cyc_wait(2);
    check("run_mode_off", MODE, 0);
    cyc_wait(1);
    check("run_pcnt_cleared", u_dut.pcnt, 0);
    cyc_wait(20);
    sb_check("run");

    // Re-entering run mode restarts the prescale period from zero.
    RUN = 1'b1;
    k = cyc + 1;
    m = k + 1;
    exp_q.push_back(m + P);
    exp_q.push_back(m + 2 * P);
    cyc_wait(12);
    RUN = 1'b0;
    cyc_wait(20);
    sb_check("run_restart");

    // Reset asserted mid-debounce at dcnt=2.
    BTN = 1'b1;
    k = cyc + 1;
    cyc_wait(4);
    check("mid_state_pw", u_dut.u_deb.state, PRESS_WAIT);
    check("mid_dcnt", u_dut.u_deb.dcnt, 2);
    CLR = 1'b0;
    #1;
    check("mid_state_idle", u_dut.u_deb.state, IDLE);
    BTN = 1'b0;
    cyc_wait(2);
    CLR = 1'b1;
    cyc_wait(20);
    sb_check("mid_reset");

    // Downstream counter: 17 presses, read before each press.
    for (int i = 0; i < 17; i++) begin
      check($sformatf("counter_before_press%0d", i), cnt, i % 16);
      BTN = 1'b1;
      k = cyc + 1;
      exp_q.push_back(k + D + 1);
      cyc_wait(8);
      BTN = 1'b0;
      cyc_wait(10);
    end
    check("counter_final", cnt, 1);
    sb_check("counter");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
